// File: rtl/cv32e40p_tmr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cv32e40p_tmr_pkg
//  Description : Shared types and constants for the TMR fault monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_tmr_pkg;

    localparam int NUM_REPLICAS = 3;

    // Health of the triplicated group, as seen by the controller/CSR side
    typedef enum logic [1:0] {
        NOMINAL      = 2'b00,
        DEGRADED     = 2'b01,
        REPLICA_LOST = 2'b10,
        FAILED       = 2'b11
    } tmr_state_e;

endpackage : cv32e40p_tmr_pkg
`default_nettype wire

// File: rtl/cv32e40p_tmr_replica_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : cv32e40p_tmr_replica_tracker
//  Description : Per-replica run counter of consecutive mismatching samples,
//                plus sticky mismatch and permanent-fault flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_tmr_replica_tracker #(
    parameter int PERM_THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic mismatch_i,
    input  logic clear_i,
    output logic mismatch_o,
    output logic perm_fault_o,
    output logic perm_fault_nxt_o
);

    localparam int                 c_RUN_W  = $clog2(PERM_THRESH + 1);
    localparam logic [c_RUN_W-1:0] c_THRESH = c_RUN_W'(PERM_THRESH);

    logic [c_RUN_W-1:0] r_run;
    logic [c_RUN_W-1:0] w_run_nxt;
    logic               w_mis_nxt;

    // Next-state of run counter and sticky flags; the perm flag is exported
    // early so the top-level FSM can react in the same cycle it is set.
    always_comb begin
        w_run_nxt        = r_run;
        w_mis_nxt        = mismatch_o;
        perm_fault_nxt_o = perm_fault_o;
        if (clear_i) begin
            w_run_nxt        = '0;
            w_mis_nxt        = 1'b0;
            perm_fault_nxt_o = 1'b0;
        end else begin
            if (valid_i) begin
                if (mismatch_i) begin
                    if (r_run != c_THRESH) begin
                        w_run_nxt = r_run + c_RUN_W'(1);
                    end
                    w_mis_nxt = 1'b1;
                end else begin
                    w_run_nxt = '0;
                end
            end
            if (w_run_nxt == c_THRESH) begin
                perm_fault_nxt_o = 1'b1;
            end
        end
    end

    // Register run counter and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run        <= '0;
            mismatch_o   <= 1'b0;
            perm_fault_o <= 1'b0;
        end else begin
            r_run        <= w_run_nxt;
            mismatch_o   <= w_mis_nxt;
            perm_fault_o <= perm_fault_nxt_o;
        end
    end

endmodule : cv32e40p_tmr_replica_tracker
`default_nettype wire

// File: rtl/cv32e40p_tmr_fault_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cv32e40p_tmr_fault_monitor
//  Description : Attributes voter disagreements to replicas, detects permanent
//                replica faults, tracks TMR group health and raises an irq.
//  Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_tmr_fault_monitor
    import cv32e40p_tmr_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PERM_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] result_i,
    input  logic [WIDTH-1:0] res1_i,
    input  logic [WIDTH-1:0] res2_i,
    input  logic [WIDTH-1:0] res3_i,
    input  logic             faulty_i,
    input  logic             clear_i,
    output logic [1:0]       state_o,
    output logic [2:0]       mismatch_o,
    output logic [2:0]       perm_fault_o,
    output logic [CNT_W-1:0] fault_cnt_o,
    output logic             alarm_o,
    output logic             irq_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    tmr_state_e                    r_state;
    tmr_state_e                    w_state_nxt;
    logic       [WIDTH-1:0]        w_res [NUM_REPLICAS];
    logic       [NUM_REPLICAS-1:0] w_mis;
    logic       [NUM_REPLICAS-1:0] w_perm_nxt;
    logic                          w_event;
    logic                          w_uncorr;
    logic                          w_clear;
    logic                          w_perm_one;
    logic                          w_perm_multi;
    logic       [CNT_W-1:0]        r_fault_cnt;
    logic                          r_irq;
    logic                          r_alarm;

    assign w_res[0] = res1_i;
    assign w_res[1] = res2_i;
    assign w_res[2] = res3_i;

    // Sample classification; everything is qualified by valid_i
    assign w_event  = valid_i && (faulty_i || (|w_mis));
    assign w_uncorr = valid_i && (res1_i != res2_i) && (res2_i != res3_i)
                              && (res1_i != res3_i);

    // Clear is honoured only outside FAILED, which is left by reset alone
    assign w_clear = clear_i && (r_state != FAILED);

    generate
        for (genvar k = 0; k < NUM_REPLICAS; k++) begin : g_replica
            assign w_mis[k] = valid_i && (w_res[k] != result_i);

            cv32e40p_tmr_replica_tracker #(
                .PERM_THRESH (PERM_THRESH)
            ) u_tracker (
                .clk              (clk),
                .rst              (rst),
                .valid_i          (valid_i),
                .mismatch_i       (w_mis[k]),
                .clear_i          (w_clear),
                .mismatch_o       (mismatch_o[k]),
                .perm_fault_o     (perm_fault_o[k]),
                .perm_fault_nxt_o (w_perm_nxt[k])
            );
        end
    endgenerate

    assign w_perm_multi = (w_perm_nxt[0] & w_perm_nxt[1]) |
                          (w_perm_nxt[0] & w_perm_nxt[2]) |
                          (w_perm_nxt[1] & w_perm_nxt[2]);
    assign w_perm_one   = (|w_perm_nxt) & ~w_perm_multi;

    // Health FSM next state, evaluated on the next-state perm flags
    always_comb begin
        w_state_nxt = r_state;
        if (w_clear) begin
            w_state_nxt = NOMINAL;
        end else if (w_uncorr || w_perm_multi) begin
            w_state_nxt = FAILED;
        end else begin
            case (r_state)
                NOMINAL: begin
                    if (w_perm_one)   w_state_nxt = REPLICA_LOST;
                    else if (w_event) w_state_nxt = DEGRADED;
                end
                DEGRADED: begin
                    if (w_perm_one)   w_state_nxt = REPLICA_LOST;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State register plus registered alarm and entry-pulse irq
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= NOMINAL;
            r_irq   <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= (w_state_nxt != r_state) &&
                       ((w_state_nxt == REPLICA_LOST) || (w_state_nxt == FAILED));
            r_alarm <= (w_state_nxt == FAILED);
        end
    end

    // Saturating fault-event counter
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_fault_cnt <= '0;
        end else if (w_event && (r_fault_cnt != c_CNT_MAX)) begin
            r_fault_cnt <= r_fault_cnt + CNT_W'(1);
        end
    end

    assign state_o     = r_state;
    assign fault_cnt_o = r_fault_cnt;
    assign irq_o       = r_irq;
    assign alarm_o     = r_alarm;

endmodule : cv32e40p_tmr_fault_monitor
`default_nettype wire

// File: doc/cv32e40p_tmr_fault_monitor.md
Name: cv32e40p_tmr_fault_monitor

Overview:
Sits directly downstream of the triplicated-multiplier voter. It consumes the voted result, the three replica results and the voter's aggregate faulty flag. Each sample, it attributes disagreements to individual replicas and detects persistent (permanent) replica faults. It tracks the health of the TMR group in a state machine and exposes saturating fault statistics, sticky status and an interrupt pulse to the controller/CSR side.

Parameters:
WIDTH, 32, width of voted and replica result vectors
PERM_THRESH, 4, consecutive mismatching valid samples that mark a replica permanently faulty (range 1..15)
CNT_W, 16, width of the saturating fault-event counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
valid_i  input  1  sample qualifier (voted ready); inputs are ignored when low
result_i  input  WIDTH  voted result
res1_i  input  WIDTH  replica 1 result
res2_i  input  WIDTH  replica 2 result
res3_i  input  WIDTH  replica 3 result
faulty_i  input  1  voter aggregate disagreement flag (covers control bits too)
clear_i  input  1  software clear of statistics and sticky status
state_o  output  2  health state: 00 NOMINAL, 01 DEGRADED, 10 REPLICA_LOST, 11 FAILED
mismatch_o  output  3  sticky per-replica "has ever mismatched since clear"
perm_fault_o  output  3  sticky per-replica permanent-fault flag
fault_cnt_o  output  CNT_W  saturating count of fault events
alarm_o  output  1  level; high while state is FAILED
irq_o  output  1  one-cycle pulse on entry to REPLICA_LOST or FAILED

Behaviour:
- Reset: all outputs 0; state NOMINAL; internal run counters 0.
- All outputs are registered. A sample at cycle N is reflected at cycle N+1.
- Per valid sample: m[k] = (res_k != result_i) for k = 1..3.
- Event = valid_i && (faulty_i || |m).
- Uncorrectable = valid_i && all three replicas pairwise different.
- Per-replica run counter:
  - valid_i && m[k]: increment, saturating at PERM_THRESH.
  - valid_i && !m[k]: reset to 0.
  - !valid_i: hold.
  - Counter reaching PERM_THRESH sets perm_fault_o[k]. The flag is sticky.
- mismatch_o[k] is set on any valid sample with m[k]. It is sticky.
- fault_cnt_o increments by 1 per event and saturates at all-ones (no wrap).
- faulty_i with m == 000 (control-bit disagreement) counts as an event and moves NOMINAL to DEGRADED, but attributes nothing to any replica.
- State transitions (evaluated on next-state flags):
  - NOMINAL -> DEGRADED on event.
  - NOMINAL/DEGRADED -> REPLICA_LOST when exactly one perm_fault bit is set.
  - Any state -> FAILED on uncorrectable, or when two or more perm_fault bits are set.
  - Direct jumps are allowed (e.g. NOMINAL -> FAILED in one cycle). irq_o pulses once per entry.
  - REPLICA_LOST -> FAILED raises a second irq_o pulse.
- FAILED is exited only by rst. While in FAILED:
  - clear_i is ignored.
  - Counters and flags keep updating; fault_cnt_o keeps counting.
- clear_i (state != FAILED):
  - Next cycle: run counters, mismatch_o, perm_fault_o and fault_cnt_o are 0; state is NOMINAL.
  - clear_i has priority: any event or sample in the same cycle is discarded.
- rst asserted mid-operation overrides everything at the next edge.
- Run counters are ceil(log2(PERM_THRESH+1)) bits wide. No arithmetic crosses WIDTH; comparisons only.

Decomposition:
- Package cv32e40p_tmr_pkg holds:
  - tmr_state_e enum (NOMINAL, DEGRADED, REPLICA_LOST, FAILED with the encodings above).
  - NUM_REPLICAS = 3.
- One sub-module, cv32e40p_tmr_replica_tracker, instantiated 3x. It contains the per-replica run counter plus sticky mismatch and perm_fault flags, with inputs valid, mismatch and clear.
- The top level holds the FSM, the event counter and irq generation.

Test Plan:
- Reset then 10 valid samples with res1=res2=res3=result=0x1234_5678, faulty_i=0 -> state 00, fault_cnt 0, all flags 0, irq never asserted.
- One valid sample with res2=0xDEAD_BEEF, others 0x1 -> next cycle: state 01, mismatch_o=010, fault_cnt 1, perm_fault 000. Following clean sample resets the run counter; later 3 consecutive res2 mismatches do not set perm_fault.
- 4 consecutive valid samples with res3 mismatching, with valid_i low for 2 cycles between samples 2 and 3 -> perm_fault_o=100 after the 4th sample, state 10, single irq pulse, fault_cnt 4.
- Single valid sample with res1=1, res2=2, res3=3 -> state 11, alarm_o=1, irq pulse. clear_i afterwards leaves state 11. Only rst returns all outputs to 0.
- clear_i in the same cycle as a mismatching sample in DEGRADED -> next cycle all stats 0, state 00, the event is not counted.
- CNT_W=4, 20 events with faulty_i=1 and m=000 -> fault_cnt_o saturates at 15, mismatch_o stays 000, state 01.
